exc_ctrl: RTL and testbench

Exception and interrupt controller for the multi-cycle MIPS core. It sits directly upstream of the control unit. It collects asynchronous external interrupt requests and synchronous exceptions (ALU overflow, invalid opcode), arbitrates between them, captures EPC and Cause, and drives a one-cycle redirect request plus handler vector into the control unit and PC source mux. It masks further interrupts until the handler executes a return-from-exception.

---
 rtl/exc_pkg.sv | 27 ++
 rtl/irq_edge_detect.sv | 45 ++++
 rtl/exc_ctrl.sv | 127 ++++++++++++
 tb/tb_exc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt controller:
// FSM state encoding, MIPS ExcCode values and Cause register field positions.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int CAUSE_CODE_LSB = 2;
  localparam int CAUSE_IP_LSB   = 8;

  // Cause layout: ExcCode in [6:2], pending snapshot in [15:8], rest zero.
  function automatic logic [31:0] build_cause(input logic [4:0] code, input logic [7:0] ip);
    logic [31:0] c;
    c = 32'd0;
    c[CAUSE_CODE_LSB +: 5] = code;
    c[CAUSE_IP_LSB +: 8]   = ip;
    return c;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge pulse generator for the external interrupt lines.
// With IRQ_SYNC_EN defined each line first passes a 2-flop synchronizer.
module irq_edge_detect #(
  parameter int N_IRQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] edge_pulse
);

  logic [N_IRQ-1:0] prev_r;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_r;
  logic [N_IRQ-1:0] sync2_r;

  // Two-stage synchronizer followed by the edge-history flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign edge_pulse = sync2_r & ~prev_r;
`else
  // Edge-history flop; inputs are already synchronous to clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_r <= '0;
    end else begin
      prev_r <= irq_in;
    end
  end

  assign edge_pulse = irq_in & ~prev_r;
`endif

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller for the multi-cycle MIPS core: arbitrates
// exceptions and interrupts, captures EPC/Cause, issues a one-cycle redirect.
// Optional macro IRQ_SYNC_EN adds 2-flop synchronizers on irq_in.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          N_IRQ       = 4,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100,
  parameter logic [31:0] IRQ_OFFSET  = 32'h0000_0080
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             exc_overflow,
  input  logic             exc_opcode,
  input  logic             instr_boundary,
  input  logic             rfe,
  input  logic [31:0]      pc_in,
  output logic             take,
  output logic [31:0]      vector,
  output logic [31:0]      epc,
  output logic [31:0]      cause,
  output logic             in_handler
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [N_IRQ-1:0] edge_s;
  logic [N_IRQ-1:0] pending_r;
  logic [N_IRQ-1:0] winner_s;
  logic [N_IRQ-1:0] clr_s;
  logic [7:0]       ip_s;
  logic             enter_s;
  logic             is_exc_s;
  logic [4:0]       code_s;
  logic             take_r;
  logic             in_handler_r;
  logic [31:0]      vector_r;
  logic [31:0]      epc_r;
  logic [31:0]      cause_r;

  irq_edge_detect #(.N_IRQ(N_IRQ)) u_edge (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .edge_pulse (edge_s)
  );

  // Lowest-index pending line is the interrupt winner.
  assign winner_s = pending_r & ~(pending_r - N_IRQ'(1'b1));

  // Arbitration and next-state: exceptions in any state, interrupts only from IDLE at a fetch.
  always_comb begin
    state_nxt_s = state_r;
    enter_s     = 1'b0;
    is_exc_s    = 1'b0;
    code_s      = EXC_INT;
    clr_s       = '0;
    ip_s        = 8'd0;
    ip_s[N_IRQ-1:0] = pending_r;
    if (exc_overflow) begin
      enter_s  = 1'b1;
      is_exc_s = 1'b1;
      code_s   = EXC_OV;
    end else if (exc_opcode) begin
      enter_s  = 1'b1;
      is_exc_s = 1'b1;
      code_s   = EXC_RI;
    end else if ((state_r == IDLE) && (|pending_r) && instr_boundary) begin
      enter_s = 1'b1;
      clr_s   = winner_s;
    end else begin
      enter_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        if (enter_s) state_nxt_s = ENTER;
        else         state_nxt_s = IDLE;
      end
      ENTER: begin
        if (enter_s) state_nxt_s = ENTER;
        else         state_nxt_s = HANDLER;
      end
      HANDLER: begin
        if (enter_s)  state_nxt_s = ENTER;
        else if (rfe) state_nxt_s = IDLE;
        else          state_nxt_s = HANDLER;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, pending set/clear (a new edge wins over the service clear) and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      take_r       <= 1'b0;
      in_handler_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pending_r    <= (pending_r & ~clr_s) | edge_s;
      take_r       <= enter_s;
      in_handler_r <= (state_nxt_s != IDLE);
    end
  end

  // EPC/Cause/vector capture; exceptions return to the already-incremented PC minus 4.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vector_r <= VECTOR_BASE;
      epc_r    <= 32'd0;
      cause_r  <= 32'd0;
    end else if (enter_s) begin
      vector_r <= is_exc_s ? VECTOR_BASE : (VECTOR_BASE + IRQ_OFFSET);
      epc_r    <= is_exc_s ? (pc_in - 32'd4) : pc_in;
      cause_r  <= build_cause(code_s, ip_s);
    end
  end

  assign take       = take_r;
  assign in_handler = in_handler_r;
  assign vector     = vector_r;
  assign epc        = epc_r;
  assign cause      = cause_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed scoreboard bench for exc_ctrl: expected redirects are queued when
// stimulus is driven and compared when take is observed.
module tb_exc_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] vec;
    logic [31:0] epc;
    logic [31:0] cause;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [3:0]  irq_in;
  logic        exc_overflow;
  logic        exc_opcode;
  logic        instr_boundary;
  logic        rfe;
  logic [31:0] pc_in;
  logic        take;
  logic [31:0] vector;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        in_handler;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  exc_ctrl #(.N_IRQ(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .irq_in         (irq_in),
    .exc_overflow   (exc_overflow),
    .exc_opcode     (exc_opcode),
    .instr_boundary (instr_boundary),
    .rfe            (rfe),
    .pc_in          (pc_in),
    .take           (take),
    .vector         (vector),
    .epc            (epc),
    .cause          (cause),
    .in_handler     (in_handler)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_cause(input logic [4:0] code, input logic [3:0] ip);
    return ({27'd0, code} << 2) | ({28'd0, ip} << 8);
  endfunction

  task automatic push(input logic [31:0] v, input logic [31:0] e, input logic [31:0] c);
    exp_t x;
    x.vec = v; x.epc = e; x.cause = c;
    sb_q.push_back(x);
  endtask

  // Waits (bounded) for take; one-shot inputs are dropped after the first edge.
  task automatic expect_take(input string tag, input int lat);
    int   cnt;
    logic seen;
    exp_t x;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < lat + 4; i++) begin
      tick();
      cnt++;
      exc_overflow = 1'b0;
      exc_opcode   = 1'b0;
      rfe          = 1'b0;
      if (take === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_take_seen"}, {31'd0, seen}, 32'd1);
    x = sb_q.pop_front();
    if (seen) begin
      check({tag, "_latency"}, cnt, lat);
      check({tag, "_vector"}, vector, x.vec);
      check({tag, "_epc"}, epc, x.epc);
      check({tag, "_cause"}, cause, x.cause);
      check({tag, "_in_handler"}, {31'd0, in_handler}, 32'd1);
    end
  endtask

  task automatic do_rfe(input string tag);
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    check({tag, "_in_handler_low"}, {31'd0, in_handler}, 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (take !== 1'b0) seen = 1'b1;
    end
    check({tag, "_no_take"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; irq_in = 4'd0; exc_overflow = 1'b0; exc_opcode = 1'b0;
    instr_boundary = 1'b0; rfe = 1'b0; pc_in = 32'd0;
    repeat (3) tick();
    check("rst_take", {31'd0, take}, 32'd0);
    check("rst_in_handler", {31'd0, in_handler}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_cause", cause, 32'd0);
    check("rst_vector", vector, 32'h0000_0100);
    reset = 1'b1;
    tick();

    // Overflow exception: EPC = PC - 4
    pc_in = 32'h10; exc_overflow = 1'b1;
    push(32'h100, 32'hC, mk_cause(5'd12, 4'd0));
    expect_take("ov", 1);
    tick();
    check("ov_handler_take_low", {31'd0, take}, 32'd0);
    do_rfe("ov");

    // rfe in IDLE is ignored
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    check("idle_rfe_take", {31'd0, take}, 32'd0);
    check("idle_rfe_in_handler", {31'd0, in_handler}, 32'd0);

    // Interrupt on line 2 at a fetch boundary
    instr_boundary = 1'b1; pc_in = 32'h40; irq_in = 4'b0100;
    push(32'h180, 32'h40, mk_cause(5'd0, 4'b0100));
    expect_take("irq2", LAT);
    tick();
    do_rfe("irq2");
    expect_quiet("irq2_pending_cleared", 6);
    irq_in = 4'd0;

    // Opcode exception beats a pending irq0; irq0 serviced after rfe
    instr_boundary = 1'b0; irq_in = 4'b0001;
    repeat (LAT - 1) tick();
    check("irq0_blocked_no_boundary", {31'd0, take}, 32'd0);
    pc_in = 32'h80; exc_opcode = 1'b1;
    push(32'h100, 32'h7C, mk_cause(5'd10, 4'b0001));
    expect_take("ri_vs_irq", 1);
    tick();
    pc_in = 32'h84; instr_boundary = 1'b1;
    push(32'h180, 32'h84, mk_cause(5'd0, 4'b0001));
    rfe = 1'b1;
    expect_take("irq0_after_rfe", 2);
    tick();
    do_rfe("irq0");
    irq_in = 4'd0;

    // Interrupt masked while in handler
    pc_in = 32'h200; exc_overflow = 1'b1;
    push(32'h100, 32'h1FC, mk_cause(5'd12, 4'd0));
    expect_take("ov2", 1);
    tick();
    irq_in = 4'b0010;
    expect_quiet("irq1_masked", LAT + 2);
    pc_in = 32'h208;
    push(32'h180, 32'h208, mk_cause(5'd0, 4'b0010));
    rfe = 1'b1;
    expect_take("irq1_after_rfe", 2);
    tick();
    do_rfe("irq1");
    irq_in = 4'd0;

    // EPC wraps at pc 0; double fault overwrites EPC/Cause
    instr_boundary = 1'b0;
    pc_in = 32'h0; exc_opcode = 1'b1;
    push(32'h100, 32'hFFFF_FFFC, mk_cause(5'd10, 4'd0));
    expect_take("ri_wrap", 1);
    tick();
    pc_in = 32'h300; exc_overflow = 1'b1;
    push(32'h100, 32'h2FC, mk_cause(5'd12, 4'd0));
    expect_take("double_fault", 1);
    tick();
    do_rfe("double_fault");

    // Reset in HANDLER with pending 0011
    irq_in = 4'b0011;
    repeat (LAT) tick();
    pc_in = 32'h400; exc_overflow = 1'b1;
    push(32'h100, 32'h3FC, mk_cause(5'd12, 4'b0011));
    expect_take("ov_pend", 1);
    tick();
    irq_in = 4'd0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_take", {31'd0, take}, 32'd0);
    check("async_rst_in_handler", {31'd0, in_handler}, 32'd0);
    check("async_rst_epc", epc, 32'd0);
    check("async_rst_cause", cause, 32'd0);
    check("async_rst_vector", vector, 32'h0000_0100);
    repeat (2) tick();
    reset = 1'b1; instr_boundary = 1'b1;
    expect_quiet("post_rst_pending_lost", 6);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
